// File: rtl/query_port_arbiter.sv
// Round-robin arbiter sharing the read RAM's single query port between N_REQ queues.
// A {valid, id, position} tag pipe matched to the RAM latency routes each result back to its requester.
module query_port_arbiter #(
    parameter int          N_REQ            = 4,
    parameter int          READ_NUM_WIDTH   = 9,
    parameter int          RAM_LAT          = 4,
    parameter logic [31:0] QUERY_COUNT_INIT = 32'd0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              stall,
    input  logic [N_REQ-1:0]                  req_valid,
    input  logic [N_REQ*READ_NUM_WIDTH-1:0]   req_read_num,
    input  logic [N_REQ*7-1:0]                req_position,
    output logic [N_REQ-1:0]                  req_ready,
    output logic [READ_NUM_WIDTH-1:0]         query_read_num_RAM_read,
    output logic [6:0]                        query_position_RAM_read,
    input  logic [7:0]                        new_read_query_RAM_read,
    output logic [N_REQ-1:0]                  resp_valid,
    output logic [7:0]                        resp_data,
    output logic [6:0]                        resp_position,
    output logic [31:0]                       query_count
);
    localparam int ID_W = $clog2(N_REQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [6:0]      position;
    } tag_t;

    logic [ID_W-1:0]           r_rr_ptr;
    logic                      r_issue_valid;
    logic [ID_W-1:0]           r_issue_id;
    logic [READ_NUM_WIDTH-1:0] r_query_read_num;
    logic [6:0]                r_query_position;
    logic [31:0]               r_query_count;
    tag_t                      r_pipe [RAM_LAT];

    logic [N_REQ-1:0]          w_req_eff;
    logic [ID_W-1:0]           w_idx;
    logic [ID_W-1:0]           w_grant_id;
    logic                      w_grant_found;
    logic [READ_NUM_WIDTH-1:0] w_sel_read_num;
    logic [6:0]                w_sel_position;
    tag_t                      w_last;

    assign w_req_eff = (stall || reset) ? '0 : req_valid;

    // Walk from the highest offset down so the lowest offset from r_rr_ptr wins.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_id    = '0;
        w_idx         = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = ID_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (w_req_eff[w_idx]) begin
                w_grant_found = 1'b1;
                w_grant_id    = w_idx;
            end
        end
    end

    always_comb begin
        req_ready      = '0;
        w_sel_read_num = '0;
        w_sel_position = '0;
        if (w_grant_found) req_ready[w_grant_id] = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                w_sel_read_num = req_read_num[i*READ_NUM_WIDTH +: READ_NUM_WIDTH];
                w_sel_position = req_position[i*7 +: 7];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr         <= '0;
            r_issue_valid    <= 1'b0;
            r_issue_id       <= '0;
            r_query_read_num <= '0;
            r_query_position <= '0;
            r_query_count    <= QUERY_COUNT_INIT;
            // NOTE: the whole tag is cleared, not just valid, so resp_position is defined after reset.
            for (int s = 0; s < RAM_LAT; s++) r_pipe[s] <= '0;
        end else if (!stall) begin
            r_issue_valid <= w_grant_found;
            if (w_grant_found) begin
                r_issue_id       <= w_grant_id;
                r_query_read_num <= w_sel_read_num;
                r_query_position <= w_sel_position;
                r_rr_ptr         <= (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
                if (r_query_count != '1) r_query_count <= r_query_count + 32'd1;
            end
            r_pipe[0] <= '{valid: r_issue_valid, id: r_issue_id, position: r_query_position};
            for (int s = 1; s < RAM_LAT; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign w_last = r_pipe[RAM_LAT-1];

    always_comb begin
        resp_valid = '0;
        if (w_last.valid && !stall && !reset) resp_valid[w_last.id] = 1'b1;
    end

    assign resp_data               = new_read_query_RAM_read;
    assign resp_position           = w_last.position;
    assign query_read_num_RAM_read = r_query_read_num;
    assign query_position_RAM_read = r_query_position;
    assign query_count             = r_query_count;

endmodule

// File: tb/tb_query_port_arbiter.sv
// Bench for query_port_arbiter: directed scenarios then random traffic, checked against
// a queue-based model of in-flight queries and a behavioural read RAM.
module tb_query_port_arbiter;
    localparam int          N_REQ    = 4;
    localparam int          RNW      = 9;
    localparam int          RAM_LAT  = 4;
    localparam logic [31:0] SAT_INIT = 32'hFFFF_FFFE;
    localparam longint      CNT_MAX  = 64'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset, stall;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*RNW-1:0]   req_read_num;
    logic [N_REQ*7-1:0]     req_position;
    logic [N_REQ-1:0]       req_ready, resp_valid;
    logic [RNW-1:0]         qrn;
    logic [6:0]             qpos, resp_position;
    logic [7:0]             ram_out, resp_data;
    logic [31:0]            query_count;
    logic [N_REQ-1:0]       s_ready, s_resp_valid;
    logic [RNW-1:0]         s_qrn;
    logic [6:0]             s_qpos, s_resp_position;
    logic [7:0]             s_resp_data;
    logic [31:0]            s_count;

    query_port_arbiter #(.N_REQ(N_REQ), .READ_NUM_WIDTH(RNW), .RAM_LAT(RAM_LAT)) dut (
        .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid),
        .req_read_num(req_read_num), .req_position(req_position), .req_ready(req_ready),
        .query_read_num_RAM_read(qrn), .query_position_RAM_read(qpos),
        .new_read_query_RAM_read(ram_out), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_position(resp_position), .query_count(query_count));

    query_port_arbiter #(.N_REQ(N_REQ), .READ_NUM_WIDTH(RNW), .RAM_LAT(RAM_LAT),
                         .QUERY_COUNT_INIT(SAT_INIT)) u_sat (
        .clk(clk), .reset(reset), .stall(stall), .req_valid(req_valid),
        .req_read_num(req_read_num), .req_position(req_position), .req_ready(s_ready),
        .query_read_num_RAM_read(s_qrn), .query_position_RAM_read(s_qpos),
        .new_read_query_RAM_read(ram_out), .resp_valid(s_resp_valid), .resp_data(s_resp_data),
        .resp_position(s_resp_position), .query_count(s_count));

    function automatic logic [7:0] ram_code(int rn, int pos);
        return 8'((rn * 29 + pos * 7 + (rn >> 4)) & 255);
    endfunction

    // Read RAM: capture stage plus extraction stages, frozen by the shared stall.
    logic [7:0] ram_pipe [RAM_LAT];
    always @(posedge clk) begin
        if (!stall) begin
            ram_pipe[0] <= ram_code(int'(qrn), int'(qpos));
            for (int i = 1; i < RAM_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign ram_out = ram_pipe[RAM_LAT-1];

    typedef struct { int id; int rn; int pos; int age; } flight_t;
    flight_t          flight [$];
    int               m_ptr, m_rn, m_pos;
    longint           m_accepts;
    bit               pend  [N_REQ];
    int               p_rn  [N_REQ];
    int               p_pos [N_REQ];
    int               errors, checks;
    logic [N_REQ-1:0] obs_ready;

    function automatic logic [63:0] sat32(longint v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(int i, int rn, int pos);
        pend[i] = 1'b1; p_rn[i] = rn; p_pos[i] = pos;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N_REQ; i++) pend[i] = 1'b0;
    endtask

    // One clock cycle: drive, compare against the model, take the edge, advance the model.
    task automatic tick();
        int g, r;
        flight_t f;
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]               = pend[i];
            req_read_num[i*RNW +: RNW] = RNW'(p_rn[i]);
            req_position[i*7 +: 7]     = 7'(p_pos[i]);
        end
        #1;
        g = -1;
        r = -1;
        if (!reset && !stall) begin
            for (int k = 0; k < N_REQ; k++)
                if (g < 0 && pend[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
            for (int i = 0; i < flight.size(); i++)
                if (flight[i].age == RAM_LAT) r = i;
        end
        obs_ready = req_ready;
        check("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        check("resp_valid", 64'(resp_valid), (r >= 0) ? (64'd1 << flight[r].id) : 64'd0);
        if (r >= 0) begin
            check("resp_position", 64'(resp_position), 64'(flight[r].pos));
            check("resp_data", 64'(resp_data), 64'(ram_code(flight[r].rn, flight[r].pos)));
        end
        check("query_read_num", 64'(qrn), 64'(m_rn));
        check("query_position", 64'(qpos), 64'(m_pos));
        check("query_count", 64'(query_count), sat32(m_accepts));
        check("sat_query_count", 64'(s_count), sat32(longint'(SAT_INIT) + m_accepts));
        check("sat_mirror", 64'({s_ready, s_resp_valid, s_qrn, s_qpos}),
              64'({req_ready, resp_valid, qrn, qpos}));
        @(posedge clk);
        if (reset) begin
            flight.delete();
            m_ptr = 0; m_rn = 0; m_pos = 0; m_accepts = 0;
        end else if (!stall) begin
            for (int i = 0; i < flight.size(); i++) flight[i].age = flight[i].age + 1;
            while (flight.size() > 0 && flight[0].age > RAM_LAT) void'(flight.pop_front());
            if (g >= 0) begin
                f.id = g; f.rn = p_rn[g]; f.pos = p_pos[g]; f.age = 0;
                flight.push_back(f);
                m_ptr = (g + 1) % N_REQ; m_rn = p_rn[g]; m_pos = p_pos[g];
                m_accepts++;
                pend[g] = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1'b1; stall = 1'b0;
        req_valid = '0; req_read_num = '0; req_position = '0;
        m_ptr = 0; m_rn = 0; m_pos = 0; m_accepts = 0;
        for (int i = 0; i < N_REQ; i++) begin pend[i] = 1'b0; p_rn[i] = 0; p_pos[i] = 0; end
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick();
        reset = 1'b0;

        // Single request from requester 2.
        set_req(2, 5, 37);
        tick();
        check("single_ready", 64'(obs_ready), 64'b0100);
        check("single_rn", 64'(qrn), 64'd5);
        check("single_pos", 64'(qpos), 64'd37);
        repeat (RAM_LAT) tick();
        check("single_resp", 64'(resp_valid), 64'b0100);
        check("single_resp_pos", 64'(resp_position), 64'd37);
        repeat (2) tick();

        // Round robin from reset with all requesters held valid.
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N_REQ; i++)
                if (!pend[i]) set_req(i, $urandom_range(0, 511), $urandom_range(0, 127));
            tick();
            check("rr_order", 64'(obs_ready), 64'd1 << (c % N_REQ));
        end
        clear_reqs();
        repeat (RAM_LAT + 2) tick();
        check("rr_count", 64'(query_count), 64'd8);

        // Stall mid-flight, with a request raised as stall rises.
        reset = 1'b1; tick(); reset = 1'b0;
        set_req(0, 100, 10); set_req(1, 200, 20);
        repeat (2) tick();
        stall = 1'b1;
        set_req(2, 300, 30);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_no_grant", 64'(obs_ready), 64'd0);
        end
        stall = 1'b0;
        repeat (RAM_LAT + 4) tick();
        check("stall_count", 64'(query_count), 64'd3);

        // Reset two cycles after three accepts.
        set_req(0, 11, 1); set_req(1, 22, 2); set_req(2, 33, 3);
        repeat (5) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_count", 64'(query_count), 64'd0);
        check("rst_rn", 64'(qrn), 64'd0);
        check("rst_pos", 64'(qpos), 64'd0);
        for (int c = 0; c < RAM_LAT + 2; c++) begin
            check("rst_no_resp", 64'(resp_valid), 64'd0);
            tick();
        end
        set_req(3, 44, 4); set_req(0, 55, 5);
        tick();
        check("rst_ptr", 64'(obs_ready), 64'b0001);
        repeat (RAM_LAT + 3) tick();

        // Boundary read_num / position values.
        set_req(3, 511, 0); set_req(1, 0, 127);
        tick();
        check("bound_rn0", 64'(qrn), 64'd0);
        check("bound_pos127", 64'(qpos), 64'd127);
        tick();
        check("bound_rn511", 64'(qrn), 64'd511);
        check("bound_pos0", 64'(qpos), 64'd0);
        repeat (RAM_LAT + 2) tick();

        // Counter saturation from a preloaded start.
        reset = 1'b1; tick(); reset = 1'b0;
        check("sat_start", 64'(s_count), 64'hFFFF_FFFE);
        set_req(0, 1, 1); set_req(1, 2, 2); set_req(2, 3, 3);
        repeat (3) tick();
        check("sat_hold", 64'(s_count), 64'hFFFF_FFFF);
        set_req(3, 4, 4);
        tick();
        check("sat_hold2", 64'(s_count), 64'hFFFF_FFFF);
        repeat (RAM_LAT + 2) tick();

        // Random traffic with stalls and occasional resets.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N_REQ; i++)
                if (!pend[i] && ($urandom_range(0, 1) == 1))
                    set_req(i, $urandom_range(0, 511), $urandom_range(0, 127));
            stall = ($urandom_range(0, 9) < 2);
            reset = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; stall = 1'b0;
        clear_reqs();
        repeat (RAM_LAT + 3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/query_port_arbiter.md
# query_port_arbiter

Shares the single query port of the read RAM between `N_REQ` pipeline queues. It grants one query per cycle with round-robin priority and drives the RAM's `query_read_num_RAM_read` / `query_position_RAM_read` inputs from registers. A requester-ID tag follows each query through a shift pipe matched to the RAM's fixed lookup latency, so the returned 8-bit base code reaches the requester that issued it. The block sits between the per-PE query queues and the read RAM and shares the global pipeline `stall`.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `READ_NUM_WIDTH`, 9: read-index width, matches the read RAM.
- `RAM_LAT`, 4: clock edges from address-register load to valid RAM output (1 capture stage + 3 extraction stages).

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `stall`  in  1: global pipeline stall, the same signal fed to the read RAM.
- `req_valid`  in  N_REQ: request pending, one bit per requester.
- `req_read_num`  in  N_REQ*READ_NUM_WIDTH: packed read index; requester i uses slice i.
- `req_position`  in  N_REQ*7: packed base position 0..127.
- `req_ready`  out  N_REQ: one-hot grant; the request is accepted on an edge where valid & ready.
- `query_read_num_RAM_read`  out  READ_NUM_WIDTH: registered address to the RAM.
- `query_position_RAM_read`  out  7: registered position to the RAM.
- `new_read_query_RAM_read`  in  8: RAM lookup result.
- `resp_valid`  out  N_REQ: one-hot; response for requester i is present this cycle.
- `resp_data`  out  8: equals `new_read_query_RAM_read`.
- `resp_position`  out  7: position of the returning query.
- `query_count`  out  32: accepted-query counter, saturating at 2^32-1.

## Operation
- Arbitration is combinational on `req_valid`. The search starts at `rr_ptr` and takes the first set bit modulo `N_REQ`.
- `req_ready` is all-zero when `stall` = 1 or no request is pending. Otherwise exactly one bit is set.
- On an accept edge:
  - the issue registers load read_num and position from the granted slice;
  - `issue_valid` is set to 1 and `issue_id` is set to the grantee;
  - `rr_ptr` is set to (grantee+1) mod `N_REQ`;
  - `query_count` increments.
- On a non-stalled edge with no grant: `issue_valid` is 0, the address registers hold their value, and `rr_ptr` holds.
- Tag pipe: `RAM_LAT` stages of {valid, id, position}. Stage 0 loads from the issue registers. Each later stage loads from the one before it. The pipe shifts only when `stall` = 0.
- `resp_valid[i]` = last_stage.valid & (last_stage.id == i) & ~stall.
- `resp_data` and `resp_position` are pass-through / last stage. Their value is don't-care when no `resp_valid` bit is set.
- Requester protocol:
  - `req_valid` and the payload must stay stable until accepted.
  - The arbiter never drops an accepted query.
  - Responses return in accept order.
- Fairness: a continuously asserted requester is granted within `N_REQ` non-stalled cycles.
- Arithmetic:
  - `rr_ptr` is ceil(log2 N_REQ) bits and wraps explicitly at `N_REQ`, not at a power of 2.
  - `query_count` is 32-bit and holds at all-ones.

## Timing
- Reset values:
  - `rr_ptr` = 0.
  - Issue registers and all tag-pipe valid bits = 0.
  - `query_read_num_RAM_read` = 0 and `query_position_RAM_read` = 0.
  - `query_count` = 0.
  - `resp_valid` = 0 and `req_ready` = 0.
- Reset overrides `stall`.
- Latency: a query accepted at edge E0 produces `resp_valid` during the cycle after edge E0+`RAM_LAT` (4 edges), provided no stall occurs.
- Each stalled cycle adds exactly one cycle of latency.
- Throughput: 1 query per non-stalled cycle; back-to-back grants to the same or different requesters are allowed.
- Stall:
  - no grant is issued;
  - the address registers, tag pipe, `rr_ptr` and `query_count` all freeze;
  - `resp_valid` is forced to 0, so a frozen response is delivered exactly once, in the first cycle after `stall` falls.
- Reset mid-flight: all in-flight tags are discarded and no response is produced for them. Requesters must re-issue.
- A request asserted on the same edge that `stall` rises is not granted.

## Test plan
- **Single request.** Requester 2 requests read_num=5, position=37 with no stall.
  - Required: `req_ready`=0100 for 1 cycle.
  - Required: `query_read_num_RAM_read`=5 and `query_position_RAM_read`=37 after that edge.
  - Required: `resp_valid`=0100 four edges later with `resp_position`=37 and `resp_data` equal to the RAM model's code.
- **Round robin.** All 4 requesters held valid for 8 cycles from reset.
  - Required: grant order 0,1,2,3,0,1,2,3.
  - Required: responses arrive in the same order, one per cycle.
  - Required: `query_count`=8.
- **Stall mid-flight.** Requests are accepted at cycles 0 and 1; `stall`=1 for cycles 2–4.
  - Required: no grants during cycles 2–4.
  - Required: responses are delayed by 3 cycles, with no duplicate and no lost `resp_valid`.
- **Reset mid-flight.** Assert `reset` 2 cycles after 3 accepts.
  - Required: no `resp_valid` for those 3 queries.
  - Required: `rr_ptr`=0, `query_count`=0, and address outputs=0.
- **Boundaries.** read_num=511 with position=0, and read_num=0 with position=127.
  - Required: exact address and position propagation; the last-slot RAM output is correct.
- **Saturation.** Preload `query_count` to 2^32-2, then accept 3 queries.
  - Required: the count holds at 2^32-1.
